// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_seq_pkg;

  localparam int unsigned PC_W_DEF        = 8;
  localparam int unsigned STACK_DEPTH_DEF = 4;
  localparam logic [PC_W_DEF-1:0] RESET_VEC_DEF = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer and instruction memory.
interface pc_sequencer_if #(
  parameter int unsigned PC_W = 8
) ();

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;

  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);

endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO; push is dropped when full, pop is dropped when empty.
module ret_stack #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] cnt;

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));
  assign top   = mem[AW'(cnt - CNT_W'(1))];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[AW'(cnt)] <= din;
      cnt           <= cnt + CNT_W'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: owns pc, runs the fetch handshake and selects the next pc.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     PC_W        = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_VEC   = PC_W'(RESET_VEC_DEF),
  parameter int unsigned     STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  pc_sequencer_if.master   imem,
  input  logic             run,
  input  logic             stall,
  output logic             instr_valid,
  input  logic             br_taken,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic             halt,
  input  logic [PC_W-1:0]  br_target,
  output logic [PC_W-1:0]  pc,
  output logic [1:0]       state,
  output logic             stack_ovf,
  output logic             stack_unf
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic            req_q, valid_q, ovf_q, unf_q;
  logic            push_c, pop_c, ovf_set_c, unf_set_c;
  logic [PC_W-1:0] stk_top;
  logic            stk_full, stk_empty;

  assign pc_inc = pc_q + PC_W'(1);

  ret_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .din   (pc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VEC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= (state_d == ST_FETCH);
      valid_q <= (state_d == ST_EXEC);
      ovf_q   <= ovf_q | ovf_set_c;
      unf_q   <= unf_q | unf_set_c;
    end
  end

  // Next state and next pc; controls only act on the non-stalled EXEC edge.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    push_c    = 1'b0;
    pop_c     = 1'b0;
    ovf_set_c = 1'b0;
    unf_set_c = 1'b0;
    case (state_q)
      ST_IDLE:  if (run) state_d = ST_FETCH;
      ST_FETCH: if (imem.imem_ack) state_d = ST_EXEC;
      ST_EXEC: begin
        if (!stall) begin
          if (halt) begin
            state_d = ST_HALT;
          end else begin
            state_d = run ? ST_FETCH : ST_IDLE;
            if (ret) begin
              if (stk_empty) begin
                unf_set_c = 1'b1;
                pc_d      = pc_inc;
              end else begin
                pop_c = 1'b1;
                pc_d  = stk_top;
              end
            end else if (call) begin
              pc_d = br_target;
              if (stk_full) ovf_set_c = 1'b1;
              else          push_c    = 1'b1;
            end else if (jump || br_taken) begin
              pc_d = br_target;
            end else begin
              pc_d = pc_inc;
            end
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign state          = state_q;
  assign stack_ovf      = ovf_q;
  assign stack_unf      = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a reference pc/stack model and a fetch-address scoreboard.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run, stall, br_taken, jump, call, ret, halt;
  logic [7:0] br_target;
  logic       instr_valid, stack_ovf, stack_unf;
  logic [7:0] pc;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0] mpc;
  logic [7:0] mstk[$];
  logic       movf, munf;
  logic [7:0] exp_q[$];

  pc_sequencer_if #(.PC_W(8)) imem_bus ();

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem_bus.master),
    .run         (run),
    .stall       (stall),
    .instr_valid (instr_valid),
    .br_taken    (br_taken),
    .jump        (jump),
    .call        (call),
    .ret         (ret),
    .halt        (halt),
    .br_target   (br_target),
    .pc          (pc),
    .state       (state),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mpc  = 8'h00;
    mstk.delete();
    movf = 1'b0;
    munf = 1'b0;
    exp_q.delete();
  endtask

  // One instruction: wait for the fetch, ack it, hold EXEC for ns stall cycles, then execute.
  task automatic step(input logic b, input logic j, input logic c, input logic r,
                      input logic h, input logic [7:0] tgt, input int ns);
    logic [7:0] exp_a;
    int n;
    n = 0;
    while (!imem_bus.imem_req && n < 20) begin
      tick();
      n++;
    end
    check("fetch_req", 32'(imem_bus.imem_req), 32'd1);
    exp_a = 8'h00;
    if (exp_q.size() > 0) exp_a = exp_q.pop_front();
    check("imem_addr", 32'(imem_bus.imem_addr), 32'(exp_a));
    imem_bus.imem_ack = 1'b1;
    tick();
    imem_bus.imem_ack = 1'b0;
    check("exec_state", 32'(state), 32'd2);
    check("exec_valid", 32'(instr_valid), 32'd1);
    check("exec_req_low", 32'(imem_bus.imem_req), 32'd0);
    br_taken = b; jump = j; call = c; ret = r; halt = h; br_target = tgt;
    for (int i = 0; i < ns; i++) begin
      stall = 1'b1;
      tick();
      check("stall_pc", 32'(pc), 32'(mpc));
      check("stall_state", 32'(state), 32'd2);
    end
    stall = 1'b0;
    tick();
    br_taken = 0; jump = 0; call = 0; ret = 0; halt = 0;
    if (h) begin
      // pc holds
    end else if (r) begin
      if (mstk.size() == 0) begin
        munf = 1'b1;
        mpc  = mpc + 8'd1;
      end else begin
        mpc = mstk.pop_back();
      end
    end else if (c) begin
      if (mstk.size() == 4) movf = 1'b1;
      else mstk.push_back(mpc + 8'd1);
      mpc = tgt;
    end else if (j || b) begin
      mpc = tgt;
    end else begin
      mpc = mpc + 8'd1;
    end
    if (!h) exp_q.push_back(mpc);
    check("next_pc", 32'(pc), 32'(mpc));
    check("next_state", 32'(state), h ? 32'd3 : (run ? 32'd1 : 32'd0));
    check("valid_pulse", 32'(instr_valid), 32'd0);
    check("ovf", 32'(stack_ovf), 32'(movf));
    check("unf", 32'(stack_unf), 32'(munf));
  endtask

  initial begin
    reset = 1'b0; run = 0; stall = 0; br_taken = 0; jump = 0; call = 0; ret = 0; halt = 0;
    br_target = 8'h00;
    imem_bus.imem_ack = 1'b0;
    model_reset();
    tick(); tick();
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_state", 32'(state), 32'd0);
    check("rst_req", 32'(imem_bus.imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_ovf", 32'(stack_ovf), 32'd0);
    check("rst_unf", 32'(stack_unf), 32'd0);
    reset = 1'b1;
    tick();
    check("idle_hold", 32'(state), 32'd0);
    run = 1'b1;
    exp_q.push_back(mpc);

    // Sequential fetches 00..03
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 8'h00, 0);

    // run low at end of EXEC parks in IDLE
    run = 1'b0;
    step(0, 0, 0, 0, 0, 8'h00, 0);
    tick(); tick();
    check("idle_park_state", 32'(state), 32'd0);
    check("idle_park_req", 32'(imem_bus.imem_req), 32'd0);
    run = 1'b1;

    // Branch to FF, then sequential wrap to 00
    step(1, 0, 0, 0, 0, 8'hFF, 0);
    step(0, 0, 0, 0, 0, 8'h00, 0);

    // Call/return at 10 -> 40 -> 11
    step(0, 1, 0, 0, 0, 8'h10, 0);
    step(0, 0, 1, 0, 0, 8'h40, 0);
    step(0, 0, 0, 1, 0, 8'h00, 0);
    check("stack_empty", 32'(dut.u_stack.empty), 32'd1);
    step(0, 0, 0, 0, 0, 8'h00, 0);

    // Five nested calls overflow a 4-deep stack, five returns underflow it
    step(0, 0, 1, 0, 0, 8'h20, 0);
    step(0, 0, 1, 0, 0, 8'h30, 0);
    step(0, 0, 1, 0, 0, 8'h50, 0);
    step(0, 0, 1, 0, 0, 8'h60, 0);
    step(0, 0, 1, 0, 0, 8'h70, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 0, 8'h00, 0);

    // Stalled jump: taken only on the first unstalled edge
    step(0, 1, 0, 0, 0, 8'h80, 3);

    // Reset while a fetch is pending takes effect before the next edge
    check("pre_reset_req", 32'(imem_bus.imem_req), 32'd1);
    reset = 1'b0;
    #1;
    check("async_req", 32'(imem_bus.imem_req), 32'd0);
    check("async_pc", 32'(pc), 32'h00);
    check("async_state", 32'(state), 32'd0);
    model_reset();
    tick();
    check("async_ovf", 32'(stack_ovf), 32'd0);
    check("async_unf", 32'(stack_unf), 32'd0);
    reset = 1'b1;
    exp_q.push_back(mpc);

    // Halt freezes everything; ack and controls afterwards are ignored
    step(0, 0, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 1, 8'h00, 0);
    imem_bus.imem_ack = 1'b1;
    jump = 1'b1;
    br_target = 8'h55;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("halt_pc", 32'(pc), 32'(mpc));
      check("halt_state", 32'(state), 32'd3);
      check("halt_req", 32'(imem_bus.imem_req), 32'd0);
      check("halt_valid", 32'(instr_valid), 32'd0);
    end
    imem_bus.imem_ack = 1'b0;
    jump = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
